// File: rtl/coh_arbiter_n.sv
// coh_arbiter_n: shared-RAM arbiter and snoop broadcaster for CPUS cores.
// Each core has an I-cache and a D-cache port. One owner at a time holds
// the RAM port. Coherence misses snoop every other cache and are filled
// either cache-to-cache (a dirty holder supplies) or from RAM. Separate
// round-robin pointers (dptr for D-side, iptr for I-side) keep grants fair.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   iREN/iaddr -> iwait/iload                 I-cache word fetch
//   dREN/dWEN/daddr/dstore -> dwait/dload     D-cache RAM access
//   cctrans/ccwrite -> ccwait/ccinv/ccsnoopaddr   coherence/snoop
//   grant_id                 index of the current owner (0 when idle)
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate   shared RAM port
//
// Handshake: a requester holds its request until its wait bit is 0 in a
// cycle (that cycle transfers the word), then drops or re-issues it. Wait
// bits fall only in a cycle where ramstate == ACCESS.
module coh_arbiter_n #(
    parameter int CPUS      = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SNOOP_CYC = 2,
    localparam int IDW      = $clog2(CPUS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*AW-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*DW-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*DW-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*DW-1:0]   dload,
    input  logic [CPUS-1:0]      cctrans,
    input  logic [CPUS-1:0]      ccwrite,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS*AW-1:0]   ccsnoopaddr,
    output logic [IDW-1:0]       grant_id,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    input  logic [DW-1:0]        ramload,
    input  logic [1:0]           ramstate
);

    localparam int SCW = (SNOOP_CYC > 1) ? $clog2(SNOOP_CYC) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_C2C, S_RAMRD, S_WB, S_IFETCH
    } state_t;

    state_t          r_state, w_state_nx;
    logic [IDW-1:0]  r_req, w_req_nx;
    logic [IDW-1:0]  r_sup, w_sup_nx;
    logic [IDW-1:0]  r_dptr, w_dptr_nx;
    logic [IDW-1:0]  r_iptr, w_iptr_nx;
    logic [SCW-1:0]  r_scnt, w_scnt_nx;

    logic            w_access;
    logic [AW-1:0]   w_req_daddr, w_sup_daddr, w_req_iaddr;
    logic [DW-1:0]   w_req_dstore, w_sup_dstore;
    logic            w_sup_found;
    logic [IDW-1:0]  w_sup_pick;
    logic            w_snoop_hold;

    // First set bit of v scanning p, p+1, ... modulo CPUS. Scanning in
    // reverse lets the nearest candidate overwrite farther ones.
    function automatic logic [IDW-1:0] rr_pick(input logic [CPUS-1:0] v,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] r;
        int idx;
        r = p;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % CPUS;
            if (v[idx]) r = IDW'(idx);
        end
        return r;
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] p);
        return (int'(p) == CPUS - 1) ? '0 : p + IDW'(1);
    endfunction

    assign w_access     = (ramstate == RAM_ACCESS);
    assign w_req_daddr  = daddr[int'(r_req)*AW +: AW];
    assign w_sup_daddr  = daddr[int'(r_sup)*AW +: AW];
    assign w_req_iaddr  = iaddr[int'(r_req)*AW +: AW];
    assign w_req_dstore = dstore[int'(r_req)*DW +: DW];
    assign w_sup_dstore = dstore[int'(r_sup)*DW +: DW];

    // Lowest-index dirty holder other than the requester.
    always_comb begin
        w_sup_found = 1'b0;
        w_sup_pick  = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != int'(r_req) && ccwrite[j]) begin
                w_sup_found = 1'b1;
                w_sup_pick  = IDW'(j);
            end
        end
    end

    // Snoopees stay frozen from the snoop until the coherence miss ends.
    assign w_snoop_hold = (r_state == S_SNOOP) || (r_state == S_C2C) ||
                          (r_state == S_RAMRD);

    always_comb begin
        w_state_nx  = r_state;
        w_req_nx    = r_req;
        w_sup_nx    = r_sup;
        w_dptr_nx   = r_dptr;
        w_iptr_nx   = r_iptr;
        w_scnt_nx   = r_scnt;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        grant_id    = (r_state == S_IDLE) ? '0 : r_req;

        if (w_snoop_hold) begin
            for (int j = 0; j < CPUS; j++) begin
                if (j != int'(r_req)) begin
                    ccwait[j]                  = 1'b1;
                    ccinv[j]                   = ccwrite[r_req];
                    ccsnoopaddr[j*AW +: AW]    = w_req_daddr;
                end
            end
        end

        case (r_state)
            S_IDLE: begin
                if (|cctrans) begin
                    w_req_nx   = rr_pick(cctrans, r_dptr);
                    w_scnt_nx  = '0;
                    w_state_nx = S_SNOOP;
                end else if (|dWEN) begin
                    w_req_nx   = rr_pick(dWEN, r_dptr);
                    w_state_nx = S_WB;
                end else if (|iREN) begin
                    w_req_nx   = rr_pick(iREN, r_iptr);
                    w_state_nx = S_IFETCH;
                end
            end
            S_SNOOP: begin
                if (!cctrans[r_req]) begin
                    w_state_nx = S_IDLE;
                end else if (r_scnt == SCW'(SNOOP_CYC - 1)) begin
                    w_sup_nx   = w_sup_pick;
                    w_state_nx = w_sup_found ? S_C2C : S_RAMRD;
                end else begin
                    w_scnt_nx  = r_scnt + SCW'(1);
                end
            end
            S_C2C: begin
                // Supplier's write-through and the requester's fill retire
                // in the same ACCESS cycle.
                ramWEN                          = dWEN[r_sup];
                ramaddr                         = w_sup_daddr;
                ramstore                        = w_sup_dstore;
                dload[int'(r_req)*DW +: DW]     = w_sup_dstore;
                dwait[r_req]                    = !w_access;
                dwait[r_sup]                    = !w_access;
                if (!cctrans[r_req]) begin
                    w_state_nx = S_IDLE;
                    w_dptr_nx  = next_id(r_req);
                end
            end
            S_RAMRD: begin
                ramREN                          = dREN[r_req];
                ramWEN                          = dWEN[r_req];
                ramaddr                         = w_req_daddr;
                dload[int'(r_req)*DW +: DW]     = ramload;
                dwait[r_req]                    = !w_access;
                if (!cctrans[r_req]) begin
                    w_state_nx = S_IDLE;
                    w_dptr_nx  = next_id(r_req);
                end
            end
            S_WB: begin
                ramWEN       = 1'b1;
                ramaddr      = w_req_daddr;
                ramstore     = w_req_dstore;
                dwait[r_req] = !w_access;
                if (w_access) begin
                    w_state_nx = S_IDLE;
                    w_dptr_nx  = next_id(r_req);
                end else if (!dWEN[r_req]) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_IFETCH: begin
                ramREN                          = 1'b1;
                ramaddr                         = w_req_iaddr;
                iload[int'(r_req)*DW +: DW]     = ramload;
                iwait[r_req]                    = !w_access;
                if (w_access) begin
                    w_state_nx = S_IDLE;
                    w_iptr_nx  = next_id(r_req);
                end else if (!iREN[r_req]) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_sup   <= '0;
            r_dptr  <= '0;
            r_iptr  <= '0;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            r_sup   <= w_sup_nx;
            r_dptr  <= w_dptr_nx;
            r_iptr  <= w_iptr_nx;
            r_scnt  <= w_scnt_nx;
        end
    end

endmodule

// File: tb/tb_coh_arbiter_n.sv
module tb_coh_arbiter_n;

    localparam int CPUS = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int EW   = 1 + 2 + DW;          // {is_ifetch, cpu, data}
    localparam logic [31:0] K = 32'h5A5A_5A5A; // RAM model: data = addr ^ K

    logic              CLK, RST;
    logic [CPUS-1:0]   iREN, dREN, dWEN, cctrans, ccwrite;
    logic [CPUS*AW-1:0] iaddr, daddr;
    logic [CPUS*DW-1:0] dstore;
    logic [CPUS-1:0]   iwait, dwait, ccwait, ccinv;
    logic [CPUS*DW-1:0] iload, dload;
    logic [CPUS*AW-1:0] ccsnoopaddr;
    logic [1:0]        grant_id;
    logic              ramREN, ramWEN;
    logic [AW-1:0]     ramaddr;
    logic [DW-1:0]     ramstore, ramload;
    logic [1:0]        ramstate;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    coh_arbiter_n #(.CPUS(CPUS), .AW(AW), .DW(DW), .SNOOP_CYC(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .grant_id(grant_id),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // RAM model: every request sees BUSY then ACCESS, repeating while held.
    assign ramload = ramaddr ^ K;
    initial begin
        ramstate = 2'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST)                   ramstate = 2'd0;
            else if (ramREN || ramWEN) ramstate = (ramstate == 2'd1) ? 2'd2 : 2'd1;
            else                       ramstate = 2'd0;
        end
    end

    // Scoreboard
    task automatic push_exp(input logic is_i, input int cpu, input logic [DW-1:0] d);
        exp_q.push_back({is_i, 2'(cpu), d});
    endtask

    task automatic sb_got(input logic is_i, input int cpu, input logic [DW-1:0] d);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got is_i=%0d cpu=%0d data=%h, required no completion",
                     is_i, cpu, d);
        end else begin
            e = exp_q.pop_front();
            if (e != {is_i, 2'(cpu), d}) begin
                errors++;
                $display("FAIL done_order: got is_i=%0d cpu=%0d data=%h, required is_i=%0d cpu=%0d data=%h",
                         is_i, cpu, d, e[EW-1], e[EW-2 -: 2], e[DW-1:0]);
            end
        end
    endtask

    // Monitor: a cleared wait bit marks a completed word.
    always @(negedge CLK) begin
        if (!RST) begin
            for (int c = 0; c < CPUS; c++) begin
                if (!dwait[c]) sb_got(1'b0, c, dload[c*DW +: DW]);
                if (!iwait[c]) sb_got(1'b1, c, iload[c*DW +: DW]);
            end
        end
    end

    // Driver helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic wait_q(input int left, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() > left && n < max_cyc) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (exp_q.size() > left) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d completions outstanding, required %0d", exp_q.size(), left);
            while (exp_q.size() > left) void'(exp_q.pop_front());
        end
    endtask

    task automatic set_i(input int c, input logic [31:0] a);
        iaddr[c*AW +: AW] = a;
    endtask

    task automatic set_d(input int c, input logic [31:0] a, input logic [31:0] s);
        daddr[c*AW +: AW]  = a;
        dstore[c*DW +: DW] = s;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iwait"},    64'(iwait),       64'hF);
        check({tag, "_dwait"},    64'(dwait),       64'hF);
        check({tag, "_ccwait"},   64'(ccwait),      64'h0);
        check({tag, "_ccinv"},    64'(ccinv),       64'h0);
        check({tag, "_snpaddr"},  64'(|ccsnoopaddr), 64'h0);
        check({tag, "_grant"},    64'(grant_id),    64'h0);
        check({tag, "_ramrw"},    64'({ramREN, ramWEN}), 64'h0);
        check({tag, "_ramaddr"},  64'(ramaddr),     64'h0);
        check({tag, "_ramstore"}, 64'(ramstore),    64'h0);
        check({tag, "_loads"},    64'(|{iload, dload}), 64'h0);
    endtask

    // Stimulus
    initial begin
        logic seen;
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        step(2);
        check_reset_outputs("rst");
        RST = 1'b0;
        step(1);

        // 1: all I-caches fetching, one word per grant in order 0,1,2,3,0
        for (int c = 0; c < CPUS; c++) set_i(c, 32'h1000_0000 + 32'(c * 16));
        iREN = 4'hF;
        push_exp(1'b1, 0, 32'h1000_0000 ^ K);
        push_exp(1'b1, 1, 32'h1000_0010 ^ K);
        push_exp(1'b1, 2, 32'h1000_0020 ^ K);
        push_exp(1'b1, 3, 32'h1000_0030 ^ K);
        push_exp(1'b1, 0, 32'h1000_0000 ^ K);
        step(1);
        check("if_grant",   64'(grant_id), 64'd0);
        check("if_ramren",  64'(ramREN),   64'd1);
        check("if_ramaddr", 64'(ramaddr),  64'h1000_0000);
        wait_q(0, 60);
        iREN = '0;
        step(2);

        // 2: cpu2 BusRd, cpu0 and cpu3 dirty -> C2C from cpu0
        set_d(2, 32'h0000_2200, 32'h0);
        set_d(0, 32'h0000_0A00, 32'hD00D_0000);
        ccwrite = 4'b1001; dWEN[0] = 1'b1; cctrans[2] = 1'b1;
        push_exp(1'b0, 0, 32'h0);
        push_exp(1'b0, 2, 32'hD00D_0000);
        step(1);
        check("c2c_snp_grant",  64'(grant_id), 64'd2);
        check("c2c_snp_ccwait", 64'(ccwait),   64'b1011);
        check("c2c_snp_ccinv",  64'(ccinv),    64'h0);
        check("c2c_snp_addr0",  64'(ccsnoopaddr[0*AW +: AW]), 64'h0000_2200);
        check("c2c_snp_addr3",  64'(ccsnoopaddr[3*AW +: AW]), 64'h0000_2200);
        check("c2c_snp_addr2",  64'(ccsnoopaddr[2*AW +: AW]), 64'h0);
        step(1);
        check("c2c_snp2_ramrw", 64'({ramREN, ramWEN}), 64'h0);
        step(1);
        check("c2c_ramwen",   64'(ramWEN),   64'd1);
        check("c2c_ramaddr",  64'(ramaddr),  64'h0000_0A00);
        check("c2c_ramstore", 64'(ramstore), 64'hD00D_0000);
        check("c2c_ccwait",   64'(ccwait),   64'b1011);
        check("c2c_ccinv",    64'(ccinv),    64'h0);
        check("c2c_dwait",    64'(dwait),    64'hF);
        wait_q(0, 20);
        cctrans = '0; ccwrite = '0; dWEN = '0;
        step(2);

        // 3: cpu1 BusRdX, no supplier -> RAMRD, invalidate others
        set_d(1, 32'h0000_1100, 32'h0);
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dREN[1] = 1'b1;
        push_exp(1'b0, 1, 32'h0000_1100 ^ K);
        step(1);
        check("rdx_grant", 64'(grant_id), 64'd1);
        check("rdx_ccinv", 64'(ccinv),    64'b1101);
        step(2);
        check("rdx_rd_ccinv",   64'(ccinv),   64'b1101);
        check("rdx_rd_ramren",  64'({ramREN, ramWEN}), 64'b10);
        check("rdx_rd_ramaddr", 64'(ramaddr), 64'h0000_1100);
        wait_q(0, 20);
        cctrans = '0; ccwrite = '0; dREN = '0;
        step(2);

        // 3b: cpu1 and cpu2 together; dptr now 2 so cpu2 wins, cpu1 waits
        set_d(1, 32'h0000_B100, 32'h0);
        set_d(2, 32'h0000_B200, 32'h0);
        cctrans = 4'b0110; dREN = 4'b0110;
        push_exp(1'b0, 2, 32'h0000_B200 ^ K);
        step(1);
        check("tie_grant",  64'(grant_id), 64'd2);
        check("tie_ccwait", 64'(ccwait),   64'b1011);
        wait_q(0, 20);
        cctrans[2] = 1'b0; dREN[2] = 1'b0;
        push_exp(1'b0, 1, 32'h0000_B100 ^ K);
        step(2);
        check("tie_loser_grant", 64'(grant_id), 64'd1);
        wait_q(0, 20);
        cctrans = '0; dREN = '0;
        step(2);

        // 4: WB from cpu3 beats IFETCH from cpu0
        set_d(3, 32'h0000_3300, 32'hCAFE_0003);
        dWEN[3] = 1'b1; iREN[0] = 1'b1;
        push_exp(1'b0, 3, 32'h0);
        push_exp(1'b1, 0, 32'h1000_0000 ^ K);
        step(1);
        check("wb_grant",    64'(grant_id), 64'd3);
        check("wb_ramwen",   64'(ramWEN),   64'd1);
        check("wb_ramaddr",  64'(ramaddr),  64'h0000_3300);
        check("wb_ramstore", 64'(ramstore), 64'hCAFE_0003);
        check("wb_iwait",    64'(iwait),    64'hF);
        wait_q(1, 20);
        dWEN = '0;
        wait_q(0, 20);
        iREN = '0;
        step(2);

        // 5: cpu0 abandons its miss during SNOOP
        set_d(0, 32'h0000_0C00, 32'h0);
        cctrans[0] = 1'b1; dREN[0] = 1'b1;
        step(1);
        check("abort_ccwait", 64'(ccwait), 64'b1110);
        cctrans[0] = 1'b0;
        seen = 1'b0;
        step(1);
        check("abort_idle_ccwait", 64'(ccwait), 64'h0);
        check("abort_idle_dwait",  64'(dwait),  64'hF);
        for (int n = 0; n < 4; n++) begin
            if (ramREN || ramWEN) seen = 1'b1;
            step(1);
        end
        check("abort_no_ram", 64'(seen), 64'd0);
        dREN = '0;
        step(1);

        // 6: reset during C2C, then lowest-index requester wins
        set_d(2, 32'h0000_E200, 32'h0);
        set_d(1, 32'h0000_E100, 32'h0);
        cctrans[2] = 1'b1; ccwrite[1] = 1'b1;
        step(3);
        check("rc_grant",   64'(grant_id), 64'd2);
        check("rc_ccwait",  64'(ccwait),   64'b1011);
        check("rc_ramaddr", 64'(ramaddr),  64'h0000_E100);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("async");
        cctrans = '0; ccwrite = '0;
        iREN = 4'b0101;
        step(2);
        RST = 1'b0;
        push_exp(1'b1, 0, 32'h1000_0000 ^ K);
        push_exp(1'b1, 2, 32'h1000_0020 ^ K);
        wait_q(0, 40);
        iREN = '0;
        step(3);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
